// File: rtl/inverse_butterfly_fsm.sv
// Inverse sum/difference butterfly: sweeps source RAMs holding S=A+B and D=A-B
// and writes the reconstructed A and B to the destination RAMs at the same address.
module inverse_butterfly_fsm #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_address,
    input  logic [DATA_W:0]   src_q_sum,
    input  logic [DATA_W:0]   src_q_diff,
    output logic [ADDR_W-1:0] dst_address,
    output logic              dst_wren,
    output logic [DATA_W-1:0] dst_data_a,
    output logic [DATA_W-1:0] dst_data_b,
    output logic [ADDR_W:0]   parity_err_count
);

    localparam int EXT_W = DATA_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   src_address_nxt;
    logic [ADDR_W-1:0]   dst_address_nxt;
    logic                dst_wren_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [ADDR_W:0]     parity_err_count_nxt;

    logic signed [EXT_W-1:0] sum_ext;
    logic signed [EXT_W-1:0] diff_ext;
    logic                    parity_bad;

    // Arithmetic shift floors odd values; low bits are all the RAM keeps.
    function automatic logic [DATA_W-1:0] half_floor(input logic signed [EXT_W-1:0] v);
        return DATA_W'(v >>> 1);
    endfunction

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign sum_ext    = signed'({2'b00, src_q_sum});
    assign diff_ext   = signed'({src_q_diff[DATA_W], src_q_diff});
    assign dst_data_a = half_floor(sum_ext + diff_ext);
    assign dst_data_b = half_floor(sum_ext - diff_ext);
    assign parity_bad = src_q_sum[0] != src_q_diff[0];

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state            <= S_IDLE;
            src_address      <= '0;
            dst_address      <= '0;
            dst_wren         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            parity_err_count <= '0;
        end else begin
            state            <= state_nxt;
            src_address      <= src_address_nxt;
            dst_address      <= dst_address_nxt;
            dst_wren         <= dst_wren_nxt;
            busy             <= busy_nxt;
            done             <= done_nxt;
            parity_err_count <= parity_err_count_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        src_address_nxt      = src_address;
        dst_address_nxt      = dst_address;
        dst_wren_nxt         = dst_wren;
        busy_nxt             = busy;
        done_nxt             = done;
        parity_err_count_nxt = parity_err_count;

        // The word on q is the one being written whenever dst_wren is high.
        if (dst_wren && parity_bad) begin
            parity_err_count_nxt = sat_inc(parity_err_count);
        end

        case (state)
            S_IDLE: begin
                dst_wren_nxt = 1'b0;
                done_nxt     = 1'b0;
                if (start) begin
                    src_address_nxt      = '0;
                    parity_err_count_nxt = '0;
                    busy_nxt             = 1'b1;
                    state_nxt            = S_RUN;
                end
            end
            S_RUN: begin
                // Destination address trails the source by the RAM read latency.
                dst_address_nxt = src_address;
                dst_wren_nxt    = 1'b1;
                if (src_address == LAST_ADDR) begin
                    state_nxt = S_DRAIN;
                end else begin
                    src_address_nxt = src_address + 1'b1;
                end
            end
            S_DRAIN: begin
                dst_wren_nxt = 1'b0;
                busy_nxt     = 1'b0;
                done_nxt     = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inverse_butterfly_fsm.sv
// Bench for inverse_butterfly_fsm: models the source/destination RAMs and checks
// reconstructed words, pass timing, parity counting and reset behaviour.
module tb_inverse_butterfly_fsm;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              CLOCK_50_I = 1'b0;
    logic              resetn     = 1'b0;
    logic              start      = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_address;
    logic [DATA_W:0]   src_q_sum;
    logic [DATA_W:0]   src_q_diff;
    logic [ADDR_W-1:0] dst_address;
    logic              dst_wren;
    logic [DATA_W-1:0] dst_data_a;
    logic [DATA_W-1:0] dst_data_b;
    logic [ADDR_W:0]   parity_err_count;

    inverse_butterfly_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLOCK_50_I       (CLOCK_50_I),
        .resetn           (resetn),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .src_address      (src_address),
        .src_q_sum        (src_q_sum),
        .src_q_diff       (src_q_diff),
        .dst_address      (dst_address),
        .dst_wren         (dst_wren),
        .dst_data_a       (dst_data_a),
        .dst_data_b       (dst_data_b),
        .parity_err_count (parity_err_count)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    logic [DATA_W:0]   s_mem [DEPTH];
    logic [DATA_W:0]   d_mem [DEPTH];
    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];
    int                wr_pass [DEPTH];
    logic [ADDR_W-1:0] src_addr_q;
    int                pass_id = 0;
    int                wr_cnt = 0;
    int                done_cnt = 0;
    int                idle_wr_cnt = 0;

    logic [DATA_W-1:0] exp_a [DEPTH];
    logic [DATA_W-1:0] exp_b [DEPTH];
    int                exp_perr;

    int tests_run = 0;
    int tests_failed = 0;

    // Source RAM: address registered inside the RAM, q read combinationally from it.
    always @(posedge CLOCK_50_I) src_addr_q <= src_address;
    assign src_q_sum  = s_mem[src_addr_q];
    assign src_q_diff = d_mem[src_addr_q];

    always @(posedge CLOCK_50_I) begin
        if (dst_wren === 1'b1) begin
            a_mem[dst_address]   <= dst_data_a;
            b_mem[dst_address]   <= dst_data_b;
            wr_pass[dst_address] <= pass_id;
            wr_cnt               <= wr_cnt + 1;
            if (busy !== 1'b1) idle_wr_cnt <= idle_wr_cnt + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_half(input int t);
        return (t >= 0) ? t / 2 : -((1 - t) / 2);
    endfunction

    function automatic int as_signed9(input logic [DATA_W:0] v);
        return v[DATA_W] ? int'(v) - (1 << (DATA_W + 1)) : int'(v);
    endfunction

    task automatic build_ref();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_a[i] = DATA_W'(floor_half(int'(s_mem[i]) + as_signed9(d_mem[i])));
            exp_b[i] = DATA_W'(floor_half(int'(s_mem[i]) - as_signed9(d_mem[i])));
            if (s_mem[i][0] != d_mem[i][0]) n++;
        end
        exp_perr = (n > (1 << (ADDR_W + 1)) - 1) ? (1 << (ADDR_W + 1)) - 1 : n;
    endtask

    task automatic load_random();
        logic [DATA_W-1:0] a, b;
        for (int i = 0; i < DEPTH; i++) begin
            a = DATA_W'($urandom_range(0, 255));
            b = DATA_W'($urandom_range(0, 255));
            s_mem[i] = {1'b0, a} + {1'b0, b};
            d_mem[i] = {1'b0, a} - {1'b0, b};
        end
    endtask

    task automatic verify(input string tag);
        int bad_pass, bad_a, bad_b;
        bad_pass = 0; bad_a = 0; bad_b = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_pass[i] != pass_id) bad_pass++;
            if (a_mem[i] !== exp_a[i]) begin
                bad_a++;
                if (bad_a == 1) chk({tag, "_a_first_bad"}, 32'(a_mem[i]), 32'(exp_a[i]));
            end
            if (b_mem[i] !== exp_b[i]) begin
                bad_b++;
                if (bad_b == 1) chk({tag, "_b_first_bad"}, 32'(b_mem[i]), 32'(exp_b[i]));
            end
        end
        chk({tag, "_addrs_written"}, 32'(bad_pass), 32'd0);
        chk({tag, "_a_mismatches"}, 32'(bad_a), 32'd0);
        chk({tag, "_b_mismatches"}, 32'(bad_b), 32'd0);
        chk({tag, "_parity_count"}, 32'(parity_err_count), 32'(exp_perr));
    endtask

    task automatic run_pass(input string tag, input bit hammer);
        int base_wr, base_done, base_idle, cyc, busy_low;
        bit got;
        base_wr = wr_cnt; base_done = done_cnt; base_idle = idle_wr_cnt;
        pass_id++;
        @(negedge CLOCK_50_I) start = 1'b1;
        @(posedge CLOCK_50_I); #1;
        chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
        chk({tag, "_accept_src_addr"}, 32'(src_address), 32'd0);
        chk({tag, "_accept_perr_clear"}, 32'(parity_err_count), 32'd0);
        cyc = 0; got = 1'b0; busy_low = 0;
        while (cyc < 2000) begin
            @(negedge CLOCK_50_I) start = hammer ? 1'($urandom) : 1'b0;
            @(posedge CLOCK_50_I); cyc++; #1;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_low++;
        end
        @(negedge CLOCK_50_I) start = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_done_latency"}, 32'(cyc), 32'(DEPTH + 1));
        chk({tag, "_busy_held"}, 32'(busy_low), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge CLOCK_50_I); #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_no_restart"}, 32'(busy), 32'd0);
        chk({tag, "_write_count"}, 32'(wr_cnt - base_wr), 32'(DEPTH));
        chk({tag, "_done_count"}, 32'(done_cnt - base_done), 32'd1);
        chk({tag, "_idle_writes"}, 32'(idle_wr_cnt - base_idle), 32'd0);
    endtask

    initial begin
        int base_wr, cyc;
        bit got;

        // Reset state
        resetn = 1'b0; start = 1'b0;
        #15;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wren", 32'(dst_wren), 32'd0);
        chk("rst_src_addr", 32'(src_address), 32'd0);
        chk("rst_dst_addr", 32'(dst_address), 32'd0);
        chk("rst_perr", 32'(parity_err_count), 32'd0);
        @(negedge CLOCK_50_I) resetn = 1'b1;
        repeat (20) begin
            @(posedge CLOCK_50_I); #1;
            chk("idle_quiet", {busy, done, dst_wren, 20'd0, src_address}, 32'd0);
        end

        // Pass 1: forward transform of A=i, B=255-i
        for (int i = 0; i < DEPTH; i++) begin
            s_mem[i] = 9'd255;
            d_mem[i] = 9'(2 * (i % 256) - 255);
            exp_a[i] = DATA_W'(i % 256);
            exp_b[i] = DATA_W'(255 - (i % 256));
        end
        exp_perr = 0;
        run_pass("ramp", 1'b0);
        verify("ramp");

        // Pass 2: random data, extremes, two parity faults, start hammered mid-pass
        load_random();
        s_mem[0] = 9'd510; d_mem[0] = 9'd0;
        s_mem[1] = 9'd0;   d_mem[1] = 9'd0;
        s_mem[2] = 9'd255; d_mem[2] = 9'h101;
        s_mem[5][0]   = ~s_mem[5][0];
        s_mem[300][0] = ~s_mem[300][0];
        build_ref();
        run_pass("rand_fault", 1'b1);
        verify("rand_fault");
        chk("perr_two", 32'(parity_err_count), 32'd2);
        chk("ext0_a", 32'(a_mem[0]), 32'd255);
        chk("ext0_b", 32'(b_mem[0]), 32'd255);
        chk("ext1_a", 32'(a_mem[1]), 32'd0);
        chk("ext1_b", 32'(b_mem[1]), 32'd0);
        chk("ext2_a", 32'(a_mem[2]), 32'd0);
        chk("ext2_b", 32'(b_mem[2]), 32'd255);
        repeat (5) @(posedge CLOCK_50_I);
        #1 chk("perr_hold", 32'(parity_err_count), 32'd2);

        // Pass 3: clean random data clears the count
        load_random();
        build_ref();
        run_pass("rand_clean", 1'b0);
        verify("rand_clean");

        // Reset at write 100 abandons the pass
        load_random();
        build_ref();
        base_wr = wr_cnt;
        pass_id++;
        @(negedge CLOCK_50_I) start = 1'b1;
        @(negedge CLOCK_50_I) start = 1'b0;
        cyc = 0; got = 1'b0;
        while (cyc < 300) begin
            @(posedge CLOCK_50_I); cyc++; #1;
            if (wr_cnt - base_wr == 100) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_mid_reached_100", 32'(got), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_wren_async", 32'(dst_wren), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_src_addr", 32'(src_address), 32'd0);
        repeat (3) @(negedge CLOCK_50_I);
        chk("rst_mid_no_writes", 32'(wr_cnt - base_wr), 32'd100);
        resetn = 1'b1;
        repeat (3) @(posedge CLOCK_50_I);
        #1 chk("rst_mid_stays_idle", {busy, done, dst_wren}, 32'd0);
        run_pass("after_rst", 1'b0);
        verify("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inverse_butterfly_fsm.md
Name: inverse_butterfly_fsm

Overview:
Inverse sum/difference (butterfly) engine. It sweeps two source RAMs that hold a widened sum S=A+B (unsigned) and difference D=A-B (two's complement). At each address it reconstructs A=(S+D)/2 and B=(S-D)/2 and writes them into two destination RAMs at the same address. It is the decode side of the forward sum/difference RAM pass and sits beside the single-port RAM megafunction instances in the lab top level, which owns the RAM instantiation and wiring.

Parameters:
ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W words are processed per pass.
DATA_W, 8, reconstructed word width. Source words are DATA_W+1 bits wide.

Ports:
CLOCK_50_I  input  1  single clock, rising edge
resetn  input  1  asynchronous, active-low reset
start  input  1  level-sampled in S_IDLE; begins one pass
busy  output  1  high from the edge that accepts start until the edge that asserts done
done  output  1  one-cycle pulse when the final destination write has been captured
src_address  output  ADDR_W  registered address to both source RAMs
src_q_sum  input  DATA_W+1  source RAM0 q, unsigned S
src_q_diff  input  DATA_W+1  source RAM1 q, two's complement D
dst_address  output  ADDR_W  registered write address to both destination RAMs
dst_wren  output  1  registered write enable to both destination RAMs
dst_data_a  output  DATA_W  combinational reconstructed A
dst_data_b  output  DATA_W  combinational reconstructed B
parity_err_count  output  ADDR_W+1  number of words in the last pass with S[0]!=D[0]

Behaviour:
- Reset (async, resetn=0): state=S_IDLE; src_address=0, dst_address=0, dst_wren=0, busy=0, done=0, parity_err_count=0. A reset mid-pass drops dst_wren immediately and abandons the pass; no resume.
- RAM timing: the source RAM registers its address internally, so q for the address set at edge k is sampled by this block at edge k+2. The destination RAM captures address/data/wren at its clock edge.
- States: S_IDLE, S_RUN, S_DRAIN.
- S_IDLE: dst_wren<=0, done<=0. If start=1, then at the same edge: src_address<=0, parity_err_count<=0, busy<=1, state<=S_RUN. Otherwise hold.
- S_RUN, every edge:
  - dst_address<=src_address; dst_wren<=1.
  - If src_address==DEPTH-1: state<=S_DRAIN. Otherwise src_address<=src_address+1.
- S_DRAIN, one edge: dst_wren<=0, busy<=0, done<=1, state<=S_IDLE. This edge captures the final write (address DEPTH-1).
- Latency/throughput:
  - Start is accepted at edge e0.
  - Destination writes are captured at edges e2 through e(DEPTH+1), one per cycle, DEPTH writes in total.
  - done is high for the single cycle after e(DEPTH+1).
  - busy is high for DEPTH+1 cycles.
- Arithmetic (combinational from src_q_*):
  - Sign-extend D and zero-extend S to DATA_W+2 bits.
  - dst_data_a = low DATA_W bits of (S+D)>>>1.
  - dst_data_b = low DATA_W bits of (S-D)>>>1.
  - The shift is arithmetic, so results floor.
  - Valid forward data always has S[0]==D[0], which makes the result exact.
- Parity check: at every edge where dst_wren=1, if src_q_sum[0]!=src_q_diff[0], parity_err_count increments, saturating at 2**(ADDR_W+1)-1. The count holds after done until the next accepted start.
- start while busy: ignored, with no restart or extension. start held high through done: a new pass is accepted at the first S_IDLE edge, i.e. one cycle after done.
- Writes happen only in S_RUN/S_DRAIN. dst_wren is never high in S_IDLE outside the drain edge.

Test Plan:
- Reset, then idle with start=0 for 20 cycles -> all outputs 0, dst_wren never 1, src_address stays 0.
- Source preloaded as the forward transform of A[i]=i[7:0], B[i]=255-i[7:0] (S=255, D=2i-255 mod 9 bits); pulse start -> destination holds A/B exactly at all 512 addresses, done pulse exactly 513 cycles after the start edge, parity_err_count=0.
- Extremes at address 0: S=510, D=0 -> A=255, B=255. At address 1: S=0, D=0 -> A=0, B=0. At address 2: S=255, D=-255 (9'h101) -> A=0, B=255.
- Corrupt S[0] at addresses 5 and 300 -> parity_err_count=2 after done, and those words hold the floored results.
- Assert start repeatedly mid-pass -> exactly 512 writes and a single done. A second pass restarts at address 0 and clears parity_err_count.
- Drop resetn at write 100 for 3 cycles -> dst_wren falls asynchronously, busy=0. A fresh start afterwards completes a full 512-word pass.
